// File: rtl/arith_sequencer.sv
// Fetch/decode sequencer driving the register-file + ALU datapath, one instruction at a time.
// Optional retire watchdog enabled by defining ARITH_SEQ_STEP_LIMIT_EN.
package arith_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
   } AluOp;
   typedef logic [4:0]  RegAddress;
   typedef logic [15:0] Immediate;
   typedef struct packed {
      logic is_ebreak;
      logic alu_use_imm;
   } InstrFlags;
   typedef struct packed {
      InstrFlags flags;
      AluOp      op;
      RegAddress dst;
      RegAddress src1;
      RegAddress src2;
      Immediate  imm;
   } Instruction;
endpackage

module arith_sequencer
   import arith_pkg::*;
#(
   parameter int PC_W      = 8,
   parameter int MAX_STEPS = 1024
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [PC_W-1:0] start_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  Instruction      imem_data,
   output AluOp            op,
   output RegAddress       dst,
   output RegAddress       src1,
   output RegAddress       src2,
   output logic            has_immediate,
   output Immediate        imm,
   output logic            reg_we,
   output logic            busy,
   output logic            halted,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     retired,
   output logic            limit_hit
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

   state_t          r_state;
   Instruction      r_ir;
   logic            r_imem_req;
   logic [PC_W-1:0] r_imem_addr;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_retired;
   logic            r_reg_we;
   logic            r_busy;
   logic            r_halted;
   logic            r_limit_hit;

   logic [PC_W-1:0] w_pc_inc;
   logic [15:0]     w_retired_inc;
   logic            w_at_limit;

   assign w_pc_inc      = r_pc + PC_W'(1);
   assign w_retired_inc = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;

`ifdef ARITH_SEQ_STEP_LIMIT_EN
   assign w_at_limit = ({16'd0, w_retired_inc} == MAX_STEPS);
   assign limit_hit  = r_limit_hit;
`else
   logic w_unused_limit;
   assign w_at_limit     = 1'b0;
   assign w_unused_limit = ({16'd0, r_retired} == MAX_STEPS) | r_limit_hit;
   assign limit_hit      = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ir        <= '0;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
         r_pc        <= '0;
         r_retired   <= '0;
         r_reg_we    <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_limit_hit <= 1'b0;
      end else begin
         r_imem_req <= 1'b0;
         r_reg_we   <= 1'b0;
         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_state     <= S_FETCH;
                  r_pc        <= start_pc;
                  r_retired   <= '0;
                  r_limit_hit <= 1'b0;
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= start_pc;
                  r_busy      <= 1'b1;
                  r_halted    <= 1'b0;
               end
            end
            S_FETCH: r_state <= S_WAIT;
            S_WAIT: begin
               // The write strobe is pre-decoded here so it is a clean register during EXEC.
               if (imem_valid) begin
                  r_ir     <= imem_data;
                  r_state  <= S_EXEC;
                  r_reg_we <= ~imem_data.flags.is_ebreak;
               end
            end
            S_EXEC: begin
               if (r_ir.flags.is_ebreak) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_pc      <= w_pc_inc;
                  r_retired <= w_retired_inc;
                  if (w_at_limit) begin
                     r_state     <= S_HALT;
                     r_busy      <= 1'b0;
                     r_halted    <= 1'b1;
                     r_limit_hit <= 1'b1;
                  end else begin
                     r_state     <= S_FETCH;
                     r_imem_req  <= 1'b1;
                     r_imem_addr <= w_pc_inc;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Control fields come straight from IR, which only changes entering EXEC.
   assign op            = r_ir.op;
   assign dst           = r_ir.dst;
   assign src1          = r_ir.src1;
   assign src2          = r_ir.src2;
   assign has_immediate = r_ir.flags.alu_use_imm;
   assign imm           = r_ir.imm;
   assign imem_req      = r_imem_req;
   assign imem_addr     = r_imem_addr;
   assign reg_we        = r_reg_we;
   assign busy          = r_busy;
   assign halted        = r_halted;
   assign pc            = r_pc;
   assign retired       = r_retired;
endmodule

// File: doc/arith_sequencer.md
# arith_sequencer

Multi-cycle instruction sequencer for the register-file + ALU arithmetic datapath. It fetches `Instruction` words from an instruction memory over a request/valid handshake and drives the datapath control fields (`op`, `dst`, `src1`, `src2`, `has_immediate`, `imm`), one instruction at a time. It gates register write-back with a one-cycle strobe and halts on `is_ebreak`. It replaces free-running index counters in front of the datapath.

## Interface
- `PC_W`, default 8: instruction-index width; the instruction memory is word-addressed, one `Instruction` per index.
- `MAX_STEPS`, default 1024: retire limit, used only when `ARITH_SEQ_STEP_LIMIT_EN` is defined.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution at `start_pc`; accepted only in IDLE or HALT.
- `start_pc`  in  PC_W  first instruction index.
- `imem_req`  out  1  one-cycle fetch request.
- `imem_addr`  out  PC_W  fetch index; valid while `imem_req`=1.
- `imem_valid`  in  1  `imem_data` is valid this cycle.
- `imem_data`  in  `Instruction`  fetched word.
- `op`  out  `AluOp`  ALU operation for the current instruction.
- `dst`, `src1`, `src2`  out  `RegAddress` (5 each)  register addresses.
- `has_immediate`  out  1  ALU B operand selects `imm`.
- `imm`  out  `Immediate`  immediate field.
- `reg_we`  out  1  register write-back strobe.
- `busy`  out  1  in FETCH, WAIT or EXEC.
- `halted`  out  1  in HALT.
- `pc`  out  PC_W  index of the current or next instruction.
- `retired`  out  16  count of instructions executed since the last accepted `start`; saturates at 16'hFFFF.
- `limit_hit`  out  1  HALT was entered via the step limit (tied 0 without the macro).

## Operation
- States: IDLE, FETCH, WAIT, EXEC, HALT. Reset state is IDLE.
- IDLE/HALT + `start`=1 → FETCH:
  - `pc` ← `start_pc`
  - `retired` ← 0
  - `limit_hit` ← 0
- FETCH: `imem_req`=1 and `imem_addr`=`pc` for exactly one cycle; always → WAIT.
- WAIT: hold until `imem_valid`=1, then latch `imem_data` into the instruction register IR and go → EXEC. `imem_valid` in any other state is ignored.
- EXEC, lasts one cycle. Control outputs are decoded from IR:
  - `{flags, op, dst, src1, src2, imm}` unpack from IR.
  - `has_immediate` = `flags.alu_use_imm`.
- EXEC with `flags.is_ebreak`=1:
  - `reg_we`=0; `pc` and `retired` are unchanged.
  - → HALT.
- EXEC otherwise:
  - `reg_we`=1
  - `pc` ← `pc`+1 (mod 2^PC_W; wraps from all-ones to 0)
  - `retired` +1 (saturating)
  - → FETCH.
- Outside EXEC, `reg_we`=0 and all control outputs hold the values from the last EXEC, so the datapath sees stable operands.
- `start` in FETCH, WAIT or EXEC is ignored.
- Register writes to `dst`=0 are issued as normal; r0 handling belongs to the register file.

## Timing
- Reset values: state IDLE; all of the following are 0:
  - `imem_req`, `imem_addr`, `pc`, `retired`, `reg_we`, `busy`, `halted`, `limit_hit`
  - IR, so `op`, `dst`, `src1`, `src2`, `has_immediate`, `imm` are all 0.
- Reset asserted mid-operation (any state) forces the reset values asynchronously. An in-flight fetch is abandoned; an `imem_valid` that arrives after release is ignored in IDLE.
- Cycle per instruction: 2 + memory latency. With `imem_valid` one cycle after `imem_req` (FETCH, WAIT, EXEC) that is 3 cycles.
- `start` at edge N: `imem_req`=1 in cycle N+1.
- EXEC at cycle E:
  - `reg_we`=1 during E; the register file captures the ALU result at the edge ending E.
  - `pc`/`retired` update at that same edge.
  - The next `imem_req` is in cycle E+1.
- `halted` rises at the edge ending the ebreak EXEC; `busy`=0 from that edge.

## Configuration
- `ARITH_SEQ_STEP_LIMIT_EN`
  - Defined: when `retired` reaches `MAX_STEPS` at the end of an EXEC, go → HALT instead of FETCH and set `limit_hit`=1. This is the runaway-program watchdog.
  - Undefined: no limit; `limit_hit` is tied 0 and `MAX_STEPS` is unused.

## Test plan
- Reset, then idle with no `start` → `imem_req`=0, `busy`=0, `halted`=0 and all outputs 0 for 20 cycles.
- Program at index 0, started with `start_pc`=0, 1-cycle memory:
  - Program: ADDI r1,r0,10; ADDI r1,r1,40; ADDI r2,r1,10; ADDI r3,r2,1; ADDI r4,r3,1; SUB r5,r4,r1; AND r6,r1,r2; EBREAK.
  - Required: r1=50, r2=60, r3=61, r4=62, r5=12, r6=48.
  - `retired`=7, `pc`=7, `halted`=1; 7 `reg_we` pulses spaced 3 cycles apart.
- Memory latency randomized between 1 and 5 cycles, same program → identical register results; exactly one `imem_req` per instruction; `reg_we` never asserted in WAIT.
- `start_pc`=8'hFF with the program wrapped around to index 0 → after index 255 the next fetch is `imem_addr`=0; the run completes correctly.
- Reset asserted during WAIT, with `imem_valid` pulsed 1 cycle after release → state is IDLE; no `reg_we`; outputs stay at reset values.
- With `ARITH_SEQ_STEP_LIMIT_EN` and `MAX_STEPS`=4, running a looping program with no EBREAK → HALT after 4 `reg_we` pulses; `limit_hit`=1, `retired`=4.
